// File: rtl/wb_downsizer_128to32.sv
// wb_downsizer_128to32
//
// Bridges a 128-bit Wishbone slave port onto a 32-bit Wishbone master port.
// Each upstream request is latched and split into one downstream beat per
// active 32-bit lane (a lane is active when any of its four byte selects is
// set). Lanes are issued lowest first. Read data is gathered into a 128-bit
// buffer and returned with a single upstream ack. A downstream error or a
// watchdog expiry aborts the remaining lanes and returns a single upstream
// error.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   s_wb_adr/sel/we/dat_i    upstream request (byte address, 16 byte selects)
//   s_wb_cyc/stb             upstream cycle/strobe
//   s_wb_dat_o               upstream read data (valid with s_wb_ack)
//   s_wb_ack/err             upstream completion/error, one-cycle pulses
//   m_wb_adr/sel/we/dat_o    downstream beat (32-bit word address, 4 selects)
//   m_wb_cyc/stb             downstream cycle/strobe
//   m_wb_dat_i               downstream read data
//   m_wb_ack/err             downstream completion/error
//
// Parameters:
//   AW       address width on both ports
//   TIMEOUT  cycles a beat may wait for ack/err before erroring; 0 = no limit
module wb_downsizer_128to32 #(
   parameter int AW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] s_wb_adr,
   input  logic [15:0]   s_wb_sel,
   input  logic          s_wb_we,
   input  logic [127:0]  s_wb_dat_i,
   output logic [127:0]  s_wb_dat_o,
   input  logic          s_wb_cyc,
   input  logic          s_wb_stb,
   output logic          s_wb_ack,
   output logic          s_wb_err,
   output logic [AW-1:0] m_wb_adr,
   output logic [3:0]    m_wb_sel,
   output logic          m_wb_we,
   output logic [31:0]   m_wb_dat_o,
   input  logic [31:0]   m_wb_dat_i,
   output logic          m_wb_cyc,
   output logic          m_wb_stb,
   input  logic          m_wb_ack,
   input  logic          m_wb_err
);

   // The watchdog only ever counts up to TIMEOUT-1 before firing.
   localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, BEAT, DONE, ERR} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [AW-5:0]  adr_q;
   logic [15:0]    sel_q;
   logic           we_q;
   logic [127:0]   dat_q;
   logic [3:0]     pending;
   logic [127:0]   rbuf;
   logic [WW-1:0]  wdog;
   logic [3:0]     req_mask;
   logic [1:0]     lane;
   logic [3:0]     lane_oh;
   logic           accept;
   logic           beat_ack;
   logic           timeout_hit;
   logic           leave;
   logic           unused_adr_bits;

   // The byte offset inside the 128-bit word is implied by the selects, so
   // the low address nibble carries no information for this bridge.
   assign unused_adr_bits = ^s_wb_adr[3:0];

   // A lane is active when any byte in it is selected.
   always_comb begin
      req_mask = '0;
      for (int k = 0; k < 4; k++) begin
         req_mask[k] = |s_wb_sel[4*k +: 4];
      end
   end

   // Current lane is the lowest pending one; later ifs win, so the lowest
   // set bit ends up selected.
   always_comb begin
      lane = 2'd3;
      if (pending[2]) lane = 2'd2;
      if (pending[1]) lane = 2'd1;
      if (pending[0]) lane = 2'd0;
   end

   assign lane_oh     = 4'b0001 << lane;
   assign timeout_hit = (TIMEOUT != 0) && (wdog == WW'(TIMEOUT - 1));
   assign leave       = (state != IDLE) && (state_nxt == IDLE);

   // State register; reset drops straight to IDLE so every output, which is
   // decoded from the state, falls to zero in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and output decode. Downstream signals are qualified with
   // s_wb_cyc so an upstream abort removes m_wb_cyc in the very same cycle.
   // Error wins over a simultaneous ack.
   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      beat_ack   = 1'b0;
      s_wb_ack   = 1'b0;
      s_wb_err   = 1'b0;
      s_wb_dat_o = '0;
      m_wb_adr   = '0;
      m_wb_sel   = '0;
      m_wb_we    = 1'b0;
      m_wb_dat_o = '0;
      m_wb_cyc   = 1'b0;
      m_wb_stb   = 1'b0;
      case (state)
         IDLE: begin
            if (s_wb_cyc && s_wb_stb) begin
               accept    = 1'b1;
               state_nxt = (|req_mask) ? BEAT : DONE;
            end
         end
         BEAT: begin
            if (!s_wb_cyc) begin
               state_nxt = IDLE;
            end else begin
               m_wb_cyc   = 1'b1;
               m_wb_stb   = 1'b1;
               m_wb_adr   = {adr_q, lane, 2'b00};
               m_wb_sel   = sel_q[{lane, 2'b00} +: 4];
               m_wb_dat_o = dat_q[{lane, 5'b00000} +: 32];
               m_wb_we    = we_q;
               if (m_wb_err) begin
                  state_nxt = ERR;
               end else if (m_wb_ack) begin
                  beat_ack = 1'b1;
                  if ((pending & ~lane_oh) == 4'b0000) begin
                     state_nxt = DONE;
                  end
               end else if (timeout_hit) begin
                  state_nxt = ERR;
               end
            end
         end
         DONE: begin
            s_wb_ack   = 1'b1;
            s_wb_dat_o = rbuf;
            state_nxt  = IDLE;
         end
         ERR: begin
            s_wb_err  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture, lane bookkeeping, read gathering and the per-beat
   // watchdog. The watchdog restarts on acceptance and after every acked
   // beat, so each beat gets its own full budget.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         adr_q   <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         dat_q   <= '0;
         pending <= '0;
         rbuf    <= '0;
         wdog    <= '0;
      end else if (accept) begin
         adr_q   <= s_wb_adr[AW-1:4];
         sel_q   <= s_wb_sel;
         we_q    <= s_wb_we;
         dat_q   <= s_wb_dat_i;
         pending <= req_mask;
         rbuf    <= '0;
         wdog    <= '0;
      end else if (leave) begin
         pending <= '0;
         rbuf    <= '0;
         wdog    <= '0;
      end else if (state == BEAT) begin
         if (beat_ack) begin
            pending <= pending & ~lane_oh;
            wdog    <= '0;
            if (!we_q) begin
               rbuf[{lane, 5'b00000} +: 32] <= m_wb_dat_i;
            end
         end else begin
            wdog <= wdog + WW'(1);
         end
      end
   end

endmodule

// File: doc/wb_downsizer_128to32.md
WB_DOWNSIZER_128TO32 -- requirements
Module: wb_downsizer_128to32

Interface
REQ-001 Parameter AW, default 32: Wishbone address width on both ports.
REQ-002 Parameter TIMEOUT, default 255: max cycles a downstream beat waits for ack/err; 0 disables the watchdog.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 s_wb_adr  input  AW  upstream byte address (from crossbar slave port).
REQ-007 s_wb_sel  input  16  upstream byte selects.
REQ-008 s_wb_we  input  1  upstream write enable.
REQ-009 s_wb_dat_i  input  128  upstream write data.
REQ-010 s_wb_dat_o  output  128  upstream read data.
REQ-011 s_wb_cyc, s_wb_stb  input  1 each  upstream cycle/strobe.
REQ-012 s_wb_ack, s_wb_err  output  1 each  upstream completion/error.
REQ-013 m_wb_adr  output  AW  downstream 32-bit-word address.
REQ-014 m_wb_sel  output  4  downstream byte selects.
REQ-015 m_wb_we  output  1  downstream write enable.
REQ-016 m_wb_dat_o  output  32  downstream write data.
REQ-017 m_wb_dat_i  input  32  downstream read data.
REQ-018 m_wb_cyc, m_wb_stb  output  1 each  downstream cycle/strobe.
REQ-019 m_wb_ack, m_wb_err  input  1 each  downstream completion/error.

Function
REQ-020 Lane k (k=0..3) = bytes 4k..4k+3 of the 128-bit word; lane k active iff |s_wb_sel[4k+3:4k].
REQ-021 States: IDLE, BEAT, DONE, ERR.
REQ-022 IDLE: on s_wb_cyc&s_wb_stb, latch adr, sel, we, dat_i; set pending mask = active lanes; clear read buffer to 0; go BEAT if mask!=0, else DONE.
REQ-023 BEAT: current lane = lowest set bit of pending; m_wb_cyc=m_wb_stb=1; m_wb_adr={adr[AW-1:4],lane[1:0],2'b00}; m_wb_sel=latched sel nibble; m_wb_dat_o=latched lane data; m_wb_we=latched we.
REQ-024 BEAT on m_wb_ack: read buffer lane <= m_wb_dat_i (reads only); clear lane bit; stay BEAT with m_wb_cyc held high if bits remain, else go DONE.
REQ-025 BEAT on m_wb_err (including simultaneous with m_wb_ack): abort remaining lanes, go ERR; err takes priority.
REQ-026 Watchdog: counter resets at each new beat; when TIMEOUT!=0 and TIMEOUT cycles elapse without ack/err, go ERR.
REQ-027 DONE: s_wb_ack=1 for exactly one cycle; s_wb_dat_o = read buffer (unselected lanes 0); go IDLE.
REQ-028 ERR: s_wb_err=1 for exactly one cycle; s_wb_dat_o = 0; go IDLE.
REQ-029 s_wb_ack and s_wb_err never both high; each lasts exactly one cycle per request.
REQ-030 Latency with zero-wait downstream (combinational ack): N active lanes -> s_wb_ack N+1 cycles after acceptance cycle; all-zero sel -> 1 cycle.
REQ-031 IDLE samples a new request no earlier than the cycle after DONE/ERR; back-to-back requests are serviced with no further gap.
REQ-032 Upstream abort: s_wb_cyc low while in BEAT -> drop m_wb_cyc/m_wb_stb that cycle, discard state, go IDLE, no s_wb_ack/s_wb_err.
REQ-033 m_wb_cyc/m_wb_stb are low in IDLE, DONE, ERR.
REQ-034 Upstream inputs changing after acceptance do not affect the request in flight.

Reset
REQ-035 rst high asynchronously forces IDLE; all outputs 0 (acks, errs, cyc, stb, we, adr, sel, data); pending mask, buffer, and watchdog cleared.
REQ-036 rst asserted mid-BEAT drops m_wb_cyc immediately; no upstream ack/err is generated for that request.

Verification
REQ-037 Read, sel=16'hFFFF, adr=0x1000, downstream returns 0x11111111..0x44444444 with 1-wait ack -> 4 beats at 0x1000/4/8/C, s_wb_dat_o=0x44444444_33333333_22222222_11111111, single s_wb_ack.
REQ-038 Write, sel=16'h0F30, dat=0xAABBCCDD_... -> exactly two beats: lane1 sel=4'b0011, lane2 sel=4'b1111, correct lane data, m_wb_we=1, then s_wb_ack.
REQ-039 sel=16'h0000 -> no m_wb_cyc activity, s_wb_ack exactly 1 cycle after acceptance, s_wb_dat_o=0.
REQ-040 Downstream m_wb_err on lane 1 of a 4-lane read -> lanes 2/3 never issued, s_wb_err one cycle, no s_wb_ack.
REQ-041 TIMEOUT=8, downstream never acks -> s_wb_err exactly 8 cycles after beat start; TIMEOUT=0 -> waits indefinitely.
REQ-042 rst pulsed during lane 2 of a write -> all outputs 0 same cycle; next request after rst processes normally from lane 0.
